// File: rtl/inp_buf_if.sv
// inp_buf_if: link-side and IM-side handshake bundle of one router input port.
//
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where the producer's vld and the consumer's rdy are both 1. The producer
// holds its payload stable while vld=1 and rdy=0; rdy may change at any time.
//
// Signals:
//   in_vld/in_data/in_eof : inbound link flit (producer = upstream router)
//   in_rdy                : buffer can take the inbound flit
//   out_vld/out_data      : FIFO head presented to the input module (IM)
//   out_eof/out_dec       : FIFO head end-of-frame and one-hot direction
//   out_rdy               : IM takes the FIFO head
//
// Modports:
//   slave  : the buffer itself (consumes in_*, produces out_*)
//   master : the environment around the buffer (link plus IM)
interface inp_buf_if #(
    parameter int DW = 8,
    parameter int SN = 4
);
    logic          in_vld;
    logic [DW-1:0] in_data;
    logic          in_eof;
    logic          in_rdy;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_eof;
    logic [SN-1:0] out_dec;
    logic          out_rdy;

    modport slave (
        input  in_vld, in_data, in_eof, out_rdy,
        output in_rdy, out_vld, out_data, out_eof, out_dec
    );

    modport master (
        output in_vld, in_data, in_eof, out_rdy,
        input  in_rdy, out_vld, out_data, out_eof, out_dec
    );
endinterface

// File: rtl/inp_buf.sv
// inp_buf: input-port buffer of the SDM-Clos router.
//
// Accepts flits from the inbound link, derives a dimension-order (XY) route
// from the head flit of each frame, and queues every flit in a small
// first-word-fall-through FIFO tagged with the frame's one-hot output
// direction. The FIFO head feeds the input module (IM).
//
// Parameters:
//   DW    flit width (even); head flit carries dest x in [DW-1:DW/2],
//         dest y in [DW/2-1:0]
//   SN    directions presented to the IM (4: all of N,E,S,W,L but DIR)
//   DEPTH FIFO entries (power of 2, >= 2)
//   DIR   direction of this port (0=N 1=E 2=S 3=W 4=L)
//   LX,LY local router coordinates (DW/2 bits unsigned)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        inp_buf_if.slave: in_vld/in_data/in_eof/in_rdy link side,
//              out_vld/out_data/out_eof/out_dec/out_rdy IM side
//   err_uturn  one-cycle pulse after accepting a head that routes to DIR
//   dbg_state  frame FSM state (0 = expecting head, 1 = inside a frame)
module inp_buf #(
    parameter int DW    = 8,
    parameter int SN    = 4,
    parameter int DEPTH = 4,
    parameter int DIR   = 0,
    parameter int LX    = 0,
    parameter int LY    = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    inp_buf_if.slave bus,
    output logic     err_uturn,
    output logic     dbg_state
);
    localparam int HW = DW / 2;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + 1 + SN;   // stored entry: {data, eof, dec}

    localparam logic [HW-1:0] LX_V     = LX[HW-1:0];
    localparam logic [HW-1:0] LY_V     = LY[HW-1:0];
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Route bit positions in the uncompressed 5-bit one-hot vector.
    localparam int R_N = 0;
    localparam int R_E = 1;
    localparam int R_S = 2;
    localparam int R_W = 3;
    localparam int R_L = 4;

    typedef enum logic {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [SN-1:0]   frame_q, frame_d;
    logic            err_q, err_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic in_rdy;
    logic out_vld;
    logic push;
    logic pop;

    // No bypass path: space freed by a pop becomes visible next cycle.
    // Holding in_rdy low during reset keeps the link from handing over a
    // flit that the reset would silently drop.
    assign in_rdy  = (count_q != CNT_FULL) & rst_n;
    assign out_vld = (count_q != '0);
    assign push    = bus.in_vld & in_rdy;
    assign pop     = out_vld & bus.out_rdy;

    // ------------------------------------------------------------------
    // XY route of the flit on the link (meaningful only for a head flit)
    // ------------------------------------------------------------------
    logic [HW-1:0] dst_x;
    logic [HW-1:0] dst_y;
    logic [4:0]    route;
    logic [SN-1:0] dec_new;
    logic          uturn;
    logic          is_head;
    logic [SN-1:0] entry_dec;

    assign dst_x   = bus.in_data[DW-1:HW];
    assign dst_y   = bus.in_data[HW-1:0];
    assign is_head = (state_q == ST_HEAD);

    // X is resolved before Y; only a flit already in the right column
    // turns N/S, and only one already at this router goes local.
    always_comb begin
        route = '0;
        if (dst_x > LX_V) begin
            route[R_E] = 1'b1;
        end else if (dst_x < LX_V) begin
            route[R_W] = 1'b1;
        end else if (dst_y > LY_V) begin
            route[R_N] = 1'b1;
        end else if (dst_y < LY_V) begin
            route[R_S] = 1'b1;
        end else begin
            route[R_L] = 1'b1;
        end
    end

    // Drop bit DIR and shift the upper bits down. A route back to DIR
    // therefore compresses to all zeros, which is exactly the u-turn code.
    always_comb begin
        dec_new = '0;
        for (int i = 0; i < SN; i++) begin
            if (i < DIR) begin
                dec_new[i] = route[i];
            end else begin
                dec_new[i] = route[i+1];
            end
        end
    end

    assign uturn     = route[DIR];
    assign entry_dec = is_head ? dec_new : frame_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (push) begin
            if (bus.in_eof) begin
                state_d = ST_HEAD;
            end else begin
                state_d = ST_BODY;
            end
        end
    end

    always_comb begin
        frame_d = frame_q;
        if (push && is_head) begin
            frame_d = dec_new;
        end
    end

    assign err_d = push & is_head & uturn;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_data, bus.in_eof, entry_dec};
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_HEAD;
            frame_q  <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: FIFO head straight from storage (first-word-fall-through)
    // ------------------------------------------------------------------
    assign bus.in_rdy  = in_rdy;
    assign bus.out_vld = out_vld;
    assign {bus.out_data, bus.out_eof, bus.out_dec} = mem_q[rd_ptr_q];

    assign err_uturn = err_q;
    assign dbg_state = (state_q == ST_BODY);
endmodule

// File: tb/tb_inp_buf.sv
// tb_inp_buf: directed bench for inp_buf. Three instances share clock and
// reset, all with LX=LY=2 and DEPTH=4: index 0 is the L port (DIR=4),
// index 1 the W port (DIR=3), index 2 the E port (DIR=1).
module tb_inp_buf;
    localparam int DW = 8;
    localparam int SN = 4;
    localparam int NDUT = 3;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Per-instance stimulus and observation
    // ------------------------------------------------------------------
    logic          in_vld   [NDUT];
    logic [DW-1:0] in_data  [NDUT];
    logic          in_eof   [NDUT];
    logic          out_rdy  [NDUT];
    logic          in_rdy_w [NDUT];
    logic          out_vld_w[NDUT];
    logic [DW-1:0] out_data_w[NDUT];
    logic          out_eof_w[NDUT];
    logic [SN-1:0] out_dec_w[NDUT];
    logic          err_w    [NDUT];
    logic          st_w     [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
        inp_buf_if #(.DW(DW), .SN(SN)) bus ();
        assign bus.in_vld    = in_vld[g];
        assign bus.in_data   = in_data[g];
        assign bus.in_eof    = in_eof[g];
        assign bus.out_rdy   = out_rdy[g];
        assign in_rdy_w[g]   = bus.in_rdy;
        assign out_vld_w[g]  = bus.out_vld;
        assign out_data_w[g] = bus.out_data;
        assign out_eof_w[g]  = bus.out_eof;
        assign out_dec_w[g]  = bus.out_dec;
        inp_buf #(
            .DW(DW), .SN(SN), .DEPTH(4), .DIR(D), .LX(2), .LY(2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .bus       (bus),
            .err_uturn (err_w[g]),
            .dbg_state (st_w[g])
        );
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are checked at that same point.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input int sel, input logic [DW-1:0] d, input logic e);
        in_vld[sel]  = 1'b1;
        in_data[sel] = d;
        in_eof[sel]  = e;
        tick();
        in_vld[sel]  = 1'b0;
    endtask

    task automatic pop_check(input int sel, input string tag, input logic [DW-1:0] d,
                             input logic e, input logic [SN-1:0] dec);
        check({tag, "_vld"},  32'(out_vld_w[sel]),  32'd1);
        check({tag, "_data"}, 32'(out_data_w[sel]), 32'(d));
        check({tag, "_eof"},  32'(out_eof_w[sel]),  32'(e));
        check({tag, "_dec"},  32'(out_dec_w[sel]),  32'(dec));
        out_rdy[sel] = 1'b1;
        tick();
        out_rdy[sel] = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < NDUT; i++) begin
            in_vld[i]  = 1'b0;
            in_data[i] = '0;
            in_eof[i]  = 1'b0;
            out_rdy[i] = 1'b0;
        end

        // Reset state
        tick();
        tick();
        for (int i = 0; i < NDUT; i++) begin
            check("rst_in_rdy",   32'(in_rdy_w[i]),   32'd0);
            check("rst_out_vld",  32'(out_vld_w[i]),  32'd0);
            check("rst_out_data", 32'(out_data_w[i]), 32'd0);
            check("rst_out_dec",  32'(out_dec_w[i]),  32'd0);
            check("rst_err",      32'(err_w[i]),      32'd0);
            check("rst_state",    32'(st_w[i]),       32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("post_rst_in_rdy", 32'(in_rdy_w[0]), 32'd1);

        // Route on the L port: 0x52 -> dx=5 > 2 -> E
        push_flit(0, 8'h52, 1'b1);
        check("route_err", 32'(err_w[0]), 32'd0);
        check("route_state", 32'(st_w[0]), 32'd0);
        pop_check(0, "route", 8'h52, 1'b1, 4'b0010);
        check("route_empty", 32'(out_vld_w[0]), 32'd0);

        // Frame hold on the W port: head 0x22 is local -> 4'b1000
        push_flit(1, 8'h22, 1'b0);
        check("frame_state_body", 32'(st_w[1]), 32'd1);
        push_flit(1, 8'hAA, 1'b0);
        push_flit(1, 8'hBB, 1'b1);
        check("frame_state_head", 32'(st_w[1]), 32'd0);
        pop_check(1, "frame0", 8'h22, 1'b0, 4'b1000);
        pop_check(1, "frame1", 8'hAA, 1'b0, 4'b1000);
        pop_check(1, "frame2", 8'hBB, 1'b1, 4'b1000);
        push_flit(1, 8'h24, 1'b1);
        pop_check(1, "frame_n", 8'h24, 1'b1, 4'b0001);

        // Full / backpressure on the L port (all route E)
        push_flit(0, 8'h61, 1'b1);
        push_flit(0, 8'h62, 1'b1);
        push_flit(0, 8'h63, 1'b1);
        check("full_not_yet", 32'(in_rdy_w[0]), 32'd1);
        push_flit(0, 8'h64, 1'b1);
        check("full_in_rdy", 32'(in_rdy_w[0]), 32'd0);
        in_vld[0]  = 1'b1;
        in_data[0] = 8'h65;
        in_eof[0]  = 1'b1;
        tick();
        check("full_held_rdy", 32'(in_rdy_w[0]), 32'd0);
        check("full_held_head", 32'(out_data_w[0]), 32'h61);
        out_rdy[0] = 1'b1;
        tick();
        out_rdy[0] = 1'b0;
        check("full_reopen", 32'(in_rdy_w[0]), 32'd1);
        check("full_next_head", 32'(out_data_w[0]), 32'h62);
        tick();
        in_vld[0] = 1'b0;
        check("full_again", 32'(in_rdy_w[0]), 32'd0);
        pop_check(0, "full_d62", 8'h62, 1'b1, 4'b0010);
        pop_check(0, "full_d63", 8'h63, 1'b1, 4'b0010);
        pop_check(0, "full_d64", 8'h64, 1'b1, 4'b0010);
        pop_check(0, "full_d65", 8'h65, 1'b1, 4'b0010);
        check("full_drained", 32'(out_vld_w[0]), 32'd0);

        // Simultaneous push/pop at occupancy 2 for 10 cycles
        push_flit(0, 8'h71, 1'b1);
        push_flit(0, 8'h72, 1'b1);
        exp_q.push_back(8'h71);
        exp_q.push_back(8'h72);
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] d;
            d = 8'h80 + 8'(i);
            in_vld[0]  = 1'b1;
            in_data[0] = d;
            in_eof[0]  = 1'b1;
            out_rdy[0] = 1'b1;
            check("pp_head", 32'(out_data_w[0]), 32'(exp_q[0]));
            check("pp_in_rdy", 32'(in_rdy_w[0]), 32'd1);
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(d);
        end
        in_vld[0]  = 1'b0;
        out_rdy[0] = 1'b0;
        pop_check(0, "pp_tail0", exp_q[0], 1'b1, 4'b0010);
        pop_check(0, "pp_tail1", exp_q[1], 1'b1, 4'b0010);
        check("pp_empty", 32'(out_vld_w[0]), 32'd0);

        // U-turn on the E port: 0x32 routes E
        push_flit(2, 8'h32, 1'b1);
        check("uturn_pulse", 32'(err_w[2]), 32'd1);
        tick();
        check("uturn_pulse_end", 32'(err_w[2]), 32'd0);
        pop_check(2, "uturn", 8'h32, 1'b1, 4'b0000);
        // Compression on the E port: L -> bit 3, W -> bit 2, S -> bit 1
        push_flit(2, 8'h22, 1'b1);
        push_flit(2, 8'h12, 1'b1);
        push_flit(2, 8'h21, 1'b1);
        check("e_no_err", 32'(err_w[2]), 32'd0);
        pop_check(2, "e_l", 8'h22, 1'b1, 4'b1000);
        pop_check(2, "e_w", 8'h12, 1'b1, 4'b0100);
        pop_check(2, "e_s", 8'h21, 1'b1, 4'b0010);

        // Reset mid-frame on the L port
        push_flit(0, 8'h52, 1'b0);
        push_flit(0, 8'hAA, 1'b0);
        push_flit(0, 8'hBB, 1'b0);
        check("mid_state_body", 32'(st_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_rdy", 32'(in_rdy_w[0]), 32'd0);
        tick();
        check("mid_rst_out_vld", 32'(out_vld_w[0]), 32'd0);
        check("mid_rst_state", 32'(st_w[0]), 32'd0);
        rst_n = 1'b1;
        push_flit(0, 8'h12, 1'b1);
        pop_check(0, "mid_head_w", 8'h12, 1'b1, 4'b1000);
        check("mid_empty", 32'(out_vld_w[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inp_buf.md
# inp_buf

Clocked input-port buffer for the SDM-Clos router. It accepts flits from an inbound link with a valid/ready handshake and computes a dimension-order (XY) route from each frame's head flit. Every flit is queued in a FIFO, tagged with the frame's one-hot output direction. The FIFO drains into the input module (IM), which consumes data, end-of-frame (eof) and the decoded direction (`deci`) for crossbar allocation.

## Interface
- `DW`, 8: flit data width; must be even.
- `SN`, 4: number of output directions presented to the IM. Fixed at 4: all of N, E, S, W, L except this port's own.
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `DIR`, 0: direction of this input port (0=N, 1=E, 2=S, 3=W, 4=L).
- `LX`, 0: local x coordinate, DW/2 bits unsigned.
- `LY`, 0: local y coordinate, DW/2 bits unsigned.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_vld` in 1: upstream flit valid.
- `in_data` in DW: flit payload. In a head flit, [DW-1:DW/2] = destination x and [DW/2-1:0] = destination y.
- `in_eof` in 1: the flit is the last of its frame.
- `in_rdy` out 1: buffer can accept a flit.
- `out_vld` out 1: FIFO head valid.
- `out_data` out DW: FIFO head payload.
- `out_eof` out 1: FIFO head eof.
- `out_dec` out SN: one-hot direction of the frame that owns the FIFO head.
- `out_rdy` in 1: IM accepts the FIFO head.
- `err_uturn` out 1: one-cycle pulse when an accepted head flit routes back to `DIR`.

## Operation
- Push occurs when `in_vld & in_rdy`. Pop occurs when `out_vld & out_rdy`.
- Input frame FSM has two states, HEAD and BODY. Reset state is HEAD.
  - HEAD plus push with `in_eof=0`: go to BODY.
  - HEAD plus push with `in_eof=1`: single-flit frame; stay in HEAD.
  - BODY plus push with `in_eof=1`: go to HEAD.
  - Otherwise: hold state.
- Route computation happens on a head push, comparing unsigned dx/dy against LX/LY:
  - dx>LX → E; dx<LX → W.
  - Otherwise dy>LY → N; dy<LY → S.
  - Otherwise → L.
- The 5-bit one-hot route `r` is compressed to SN bits by deleting bit DIR; higher bits shift down by one. Example: DIR=1 gives `out_dec = {r[4], r[3], r[2], r[0]}`.
- U-turn case (r[DIR]=1):
  - the compressed `dec` is 4'b0000;
  - `err_uturn` pulses on the cycle after the push;
  - the frame is still buffered and delivered with `out_dec=0`.
- Direction is registered in a frame register on the head push. Each entry stores `{data, eof, dec}`. Body flits store the frame register's value; the head stores the freshly computed value.
- FIFO uses read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
  - Push without pop: count +1.
  - Pop without push: count −1.
  - Both together: count unchanged.
- `in_rdy = (count != DEPTH) & rst_n`. There is no bypass, so a pop does not free space in the same cycle.
- `out_vld = (count != 0)`. Output is first-word-fall-through: `out_data`, `out_eof` and `out_dec` come directly from the entry at the read pointer.
- Outputs hold steady while `out_vld & ~out_rdy`.

## Timing
- Latency: a flit pushed at edge k is visible on `out_*` with `out_vld=1` after edge k, in cycle k+1. Minimum in-to-out latency is 1 cycle.
- Throughput is 1 flit/cycle when `out_rdy` is held at 1.
- Full: `in_rdy=0` in the cycle when count=DEPTH. It rises the cycle after a pop.
- Empty: `out_vld=0` and `out_data/out_eof/out_dec` are don't-care, but must not be X after reset.
- Reset (`rst_n=0` sampled at an edge):
  - pointers=0, count=0, FSM=HEAD, frame register=0, `err_uturn`=0;
  - `out_vld`=0;
  - `in_rdy` is 0 combinationally while `rst_n=0`;
  - storage array contents are zeroed.
- Reset mid-frame discards all buffered flits. The next accepted flit is treated as a head.

## Test plan
- Route, DIR=4 (L), LX=LY=2: push head 0x52, eof=1 → next cycle `out_vld=1`, `out_data=0x52`, `out_eof=1`, `out_dec=4'b0010` (E).
- Frame hold, DIR=3 (W), LX=LY=2: push frames 0x22, 0xAA, 0xBB (eof on 0xBB) → all three pop with `out_dec=4'b1000` (L, after compressing out W). The following head 0x24 yields N, `out_dec=4'b0001`.
- Full/backpressure, DEPTH=4: hold `out_rdy=0` and push 5 flits → `in_rdy=0` after the 4th push and the 5th is held. Raise `out_rdy` for 1 cycle → `in_rdy=1` the next cycle; order is preserved.
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2 and pointers wrap correctly; the output sequence equals the input sequence.
- U-turn, DIR=1 (E), LX=LY=2: head 0x32 → `err_uturn=1` for exactly one cycle, and the flit is delivered with `out_dec=0`.
- Reset mid-frame: after head 0x52 (eof=0) plus 2 body flits, assert `rst_n=0` for one edge → `out_vld=0`. The next push, 0x12 with eof=1, is treated as a head and routes W.
